instr_fetch: RTL and testbench

Instruction fetch responder for the RISC-V unicycle core. It consumes the word-indexed program counter, reads the addressed word from instruction memory over a request/grant/response interface, and presents the instruction to decode. It holds the program counter while a fetch is outstanding and raises the sticky `finish_flag` when a halt instruction, an out-of-range PC or a memory timeout occurs. The top level drives the PC's `finish_flag` input with `finish_flag | pc_hold`.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch_watchdog.sv | 40 ++++
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
package ifetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HALT = 2'd3
   } ifetch_state_t;

   localparam logic [31:0] PC_INVALID   = 32'hFFFF_FFFF;
   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   // True for the two instructions that stop the core.
   function automatic logic is_halt_instr(input logic [31:0] word);
      return (word == INSTR_ECALL) || (word == INSTR_EBREAK);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/grant/response bus.
// master: fetch unit side, slave: memory side.
interface instr_fetch_if #(
   parameter int ADDR_W = 10
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/instr_fetch_watchdog.sv
// Fetch watchdog: counts cycles spent in REQ/WAIT and flags expiry on the
// last allowed cycle. Only instantiated when IFETCH_TIMEOUT_EN is defined.
module ifetch_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,     // synchronous, active low
   input  logic clear,     // fetch is entering REQ
   input  logic count_en,  // fetch is in REQ or WAIT
   output logic expired
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Expiry marks the final allowed cycle; the FSM halts at the next edge
   // unless a response arrives in this very cycle.
   assign expired = count_en && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next count: clear on a new fetch, otherwise advance while busy.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch responder: fetches the word addressed by pc_reg over the
// request/grant/response bus, holds the PC while busy and raises sticky
// finish/fault flags on a halt instruction, an out-of-range PC or (with
// IFETCH_TIMEOUT_EN defined) a memory timeout.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter int ADDR_W         = 10,
   parameter int DEPTH          = 1024,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic          clk,
   input  logic          reset,        // synchronous, active low
   input  logic [31:0]   pc_reg,
   instr_fetch_if.master mem,
   output logic [31:0]   instr,
   output logic          instr_valid,
   output logic          pc_hold,
   output logic          finish_flag,
   output logic          fault
);

   // Elaboration-time parameter sanity.
   generate
      if (DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
         $error("instr_fetch: DEPTH exceeds the address space");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("instr_fetch: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   ifetch_state_t     state_q, state_d;
   logic [31:0]       fetched_pc_q, fetched_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       instr_q, instr_d;
   logic              instr_valid_q, instr_valid_d;
   logic              finish_q, finish_d;
   logic              fault_q, fault_d;

   logic pc_new;
   logic pc_out_of_range;
   logic enter_req;
   logic timeout_hit;

   assign pc_new          = (pc_reg != PC_INVALID) && (pc_reg != fetched_pc_q);
   assign pc_out_of_range = (pc_reg >= 32'(DEPTH));

`ifdef IFETCH_TIMEOUT_EN
   logic wd_expired;

   ifetch_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear    (enter_req),
      .count_en ((state_q == S_REQ) || (state_q == S_WAIT)),
      .expired  (wd_expired)
   );

   assign timeout_hit = wd_expired;
`else
   // Without the watchdog a fetch waits indefinitely for its response.
   assign timeout_hit = 1'b0;
`endif

   // Next-state and register updates; a response in the expiry cycle wins.
   always_comb begin
      state_d       = state_q;
      fetched_pc_d  = fetched_pc_q;
      addr_d        = addr_q;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      finish_d      = finish_q;
      fault_d       = fault_q;
      enter_req     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Responses arriving here are stale (e.g. after a reset) and dropped.
            if (pc_new) begin
               if (pc_out_of_range) begin
                  state_d  = S_HALT;
                  finish_d = 1'b1;
                  fault_d  = 1'b1;
               end else begin
                  fetched_pc_d = pc_reg;
                  addr_d       = pc_reg[ADDR_W-1:0];
                  enter_req    = 1'b1;
                  state_d      = S_REQ;
               end
            end
         end
         S_REQ: begin
            // rvalid alongside the grant cannot belong to this request.
            if (timeout_hit) begin
               state_d  = S_HALT;
               finish_d = 1'b1;
               fault_d  = 1'b1;
            end else if (mem.mem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem.mem_rvalid) begin
               instr_d       = mem.mem_rdata;
               instr_valid_d = 1'b1;
               if (is_halt_instr(mem.mem_rdata)) begin
                  state_d  = S_HALT;
                  finish_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (timeout_hit) begin
               state_d  = S_HALT;
               finish_d = 1'b1;
               fault_d  = 1'b1;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         fetched_pc_q  <= PC_INVALID;
         addr_q        <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         finish_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetched_pc_q  <= fetched_pc_d;
         addr_q        <= addr_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         finish_q      <= finish_d;
         fault_q       <= fault_d;
      end
   end

   // The PC may only advance while idle with nothing new to fetch.
   assign pc_hold      = (state_q != S_IDLE) || pc_new;
   assign mem.mem_req  = (state_q == S_REQ);
   assign mem.mem_addr = addr_q;
   assign instr        = instr_q;
   assign instr_valid  = instr_valid_q;
   assign finish_flag  = finish_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: the bench plays both the PC and the instruction
// memory. Expected values come from a word array model and the protocol rules.
module tb_instr_fetch;

   localparam int ADDR_W         = 10;
   localparam int DEPTH          = 1024;
   localparam int TIMEOUT_CYCLES = 16;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_reg;
   logic [31:0] instr;
   logic        instr_valid;
   logic        pc_hold;
   logic        finish_flag;
   logic        fault;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] mem_model [DEPTH];
   logic [31:0] last_pc;

   instr_fetch_if #(.ADDR_W(ADDR_W)) mem_bus ();

   instr_fetch #(
      .ADDR_W         (ADDR_W),
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_reg      (pc_reg),
      .mem         (mem_bus.master),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc_hold     (pc_hold),
      .finish_flag (finish_flag),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   // Stimulus only: hold reset low with no valid PC, release on a negedge.
   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset              = 1'b0;
      pc_reg             = 32'hFFFF_FFFF;
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      repeat (cycles) @(negedge clk);
      reset = 1'b1;
   endtask

   // Drives one fetch: the PC changes, the memory grants after gd extra
   // request cycles and answers rd cycles after the grant. Returns what it saw.
   task automatic run_fetch(input logic [31:0] pc, input logic [31:0] word,
                            input int gd, input int rd, input bit junk_rv,
                            output int valid_cnt, output int valid_cyc,
                            output int req_cyc, output logic [31:0] instr_seen,
                            output int hold_bad, output int addr_bad,
                            output logic hold_at_t, output logic hold_at_valid,
                            output logic extra_pulse);
      int  cyc, since_gnt;
      bit  granted, responded, done;
      logic [ADDR_W-1:0] exp_addr;
      exp_addr = pc[ADDR_W-1:0];
      valid_cnt = 0; valid_cyc = -1; req_cyc = 0; instr_seen = '0;
      hold_bad = 0; addr_bad = 0; hold_at_valid = 1'b0;
      since_gnt = 0; granted = 0; responded = 0; done = 0; cyc = 0;
      @(negedge clk);
      pc_reg             = pc;
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      #1 hold_at_t = pc_hold;
      while (!done && cyc < 64) begin
         @(negedge clk);
         cyc++;
         mem_bus.mem_gnt    = 1'b0;
         mem_bus.mem_rvalid = 1'b0;
         mem_bus.mem_rdata  = 32'hDEAD_0000 | 32'($urandom_range(0, 16'hFFFF));
         if (instr_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc     = cyc;
            instr_seen    = instr;
            hold_at_valid = pc_hold;
            done          = 1;
         end else if (pc_hold !== 1'b1) begin
            hold_bad++;
         end
         if (mem_bus.mem_req === 1'b1) begin
            req_cyc++;
            if (mem_bus.mem_addr !== exp_addr) addr_bad++;
            if (req_cyc == gd + 1) begin
               mem_bus.mem_gnt = 1'b1;
               granted         = 1;
               if (junk_rv) mem_bus.mem_rvalid = 1'b1;
            end
         end else if (granted && !responded) begin
            since_gnt++;
            if (since_gnt >= rd) begin
               mem_bus.mem_rvalid = 1'b1;
               mem_bus.mem_rdata  = word;
               responded          = 1;
            end
         end
      end
      @(negedge clk);
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      extra_pulse        = instr_valid;
      last_pc            = pc;
   endtask

   task automatic test_reset();
      do_reset(3);
      repeat (5) @(negedge clk);
      total_cnt++; if (mem_bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_bus.mem_req); else pass_cnt++;
      total_cnt++; if (pc_hold !== 1'b0) $display("FAIL reset_pc_hold got=%b exp=0", pc_hold); else pass_cnt++;
      total_cnt++; if (mem_bus.mem_addr !== '0) $display("FAIL reset_mem_addr got=%h exp=0", mem_bus.mem_addr); else pass_cnt++;
      total_cnt++; if (instr !== 32'h0) $display("FAIL reset_instr got=%h exp=0", instr); else pass_cnt++;
      total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); else pass_cnt++;
      total_cnt++; if (finish_flag !== 1'b0) $display("FAIL reset_finish got=%b exp=0", finish_flag); else pass_cnt++;
      total_cnt++; if (fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", fault); else pass_cnt++;
      $display("reset: outputs sampled after 5 idle cycles");
   endtask

   task automatic test_basic_fetch();
      int vc, vcyc, rc, hb, ab; logic [31:0] iv; logic ht, hv, ep;
      mem_model[0] = 32'h0050_0093;
      run_fetch(32'd0, mem_model[0], 0, 1, 1'b0, vc, vcyc, rc, iv, hb, ab, ht, hv, ep);
      $display("basic: pc=0 instr=%h latency=%0d", iv, vcyc);
      total_cnt++; if (ht !== 1'b1) $display("FAIL basic_hold_at_t got=%b exp=1", ht); else pass_cnt++;
      total_cnt++; if (vc != 1) $display("FAIL basic_valid_count got=%0d exp=1", vc); else pass_cnt++;
      total_cnt++; if (vcyc != 3) $display("FAIL basic_latency got=%0d exp=3", vcyc); else pass_cnt++;
      total_cnt++; if (iv !== 32'h0050_0093) $display("FAIL basic_instr got=%h exp=00500093", iv); else pass_cnt++;
      total_cnt++; if (hv !== 1'b0) $display("FAIL basic_hold_at_valid got=%b exp=0", hv); else pass_cnt++;
      total_cnt++; if (rc != 1) $display("FAIL basic_req_cycles got=%0d exp=1", rc); else pass_cnt++;
      total_cnt++; if (ab != 0) $display("FAIL basic_mem_addr bad_cycles=%0d exp=0", ab); else pass_cnt++;
      total_cnt++; if (ep !== 1'b0) $display("FAIL basic_second_pulse got=%b exp=0", ep); else pass_cnt++;
   endtask

   task automatic test_delayed_mem();
      int vc, vcyc, rc, hb, ab; logic [31:0] iv; logic ht, hv, ep;
      run_fetch(32'd1, mem_model[1], 2, 2, 1'b0, vc, vcyc, rc, iv, hb, ab, ht, hv, ep);
      $display("delayed: pc=1 instr=%h req_cycles=%0d latency=%0d", iv, rc, vcyc);
      total_cnt++; if (rc != 3) $display("FAIL delayed_req_cycles got=%0d exp=3", rc); else pass_cnt++;
      total_cnt++; if (hb != 0) $display("FAIL delayed_hold_drop cycles=%0d exp=0", hb); else pass_cnt++;
      total_cnt++; if (vc != 1) $display("FAIL delayed_valid_count got=%0d exp=1", vc); else pass_cnt++;
      total_cnt++; if (iv !== mem_model[1]) $display("FAIL delayed_instr got=%h exp=%h", iv, mem_model[1]); else pass_cnt++;
      total_cnt++; if (ep !== 1'b0) $display("FAIL delayed_second_pulse got=%b exp=0", ep); else pass_cnt++;
   endtask

   task automatic test_random_fetch();
      int vc, vcyc, rc, hb, ab, gd, rd; logic [31:0] iv, pc; logic ht, hv, ep; bit jr;
      for (int n = 0; n < 20; n++) begin
         do pc = 32'($urandom_range(3, DEPTH - 1)); while (pc == last_pc);
         gd = $urandom_range(0, 3);
         rd = $urandom_range(1, 3);
         jr = 1'($urandom_range(0, 1));
         run_fetch(pc, mem_model[pc], gd, rd, jr, vc, vcyc, rc, iv, hb, ab, ht, hv, ep);
         $display("random: pc=%0d gnt_dly=%0d rsp_dly=%0d instr=%h", pc, gd, rd, iv);
         total_cnt++; if (iv !== mem_model[pc] || vc != 1) $display("FAIL rand_instr pc=%0d got=%h cnt=%0d exp=%h cnt=1", pc, iv, vc, mem_model[pc]); else pass_cnt++;
         total_cnt++; if (rc != gd + 1 || ab != 0) $display("FAIL rand_req pc=%0d req_cycles=%0d bad_addr=%0d exp=%0d/0", pc, rc, ab, gd + 1); else pass_cnt++;
         total_cnt++; if (hb != 0 || hv !== 1'b0 || ep !== 1'b0) $display("FAIL rand_hold pc=%0d drops=%0d hold_at_valid=%b extra=%b exp=0/0/0", pc, hb, hv, ep); else pass_cnt++;
      end
      // Unchanged PC: nothing to fetch, nothing held.
      begin
         int reqs = 0, holds = 0;
         repeat (4) begin
            @(negedge clk);
            if (mem_bus.mem_req === 1'b1) reqs++;
            if (pc_hold !== 1'b0) holds++;
         end
         $display("same_pc: pc=%0d req_cycles=%0d hold_cycles=%0d", pc_reg, reqs, holds);
         total_cnt++; if (reqs != 0 || holds != 0) $display("FAIL same_pc req=%0d hold=%0d exp=0/0", reqs, holds); else pass_cnt++;
      end
   endtask

   task automatic test_reset_in_wait();
      int vc, vcyc, rc, hb, ab; logic [31:0] iv; logic ht, hv, ep;
      do_reset(2);
      @(negedge clk); pc_reg = 32'd9;
      @(negedge clk);
      total_cnt++; if (mem_bus.mem_req !== 1'b1) $display("FAIL abort_req got=%b exp=1", mem_bus.mem_req); else pass_cnt++;
      mem_bus.mem_gnt = 1'b1;
      @(negedge clk);
      mem_bus.mem_gnt = 1'b0;
      reset  = 1'b0;
      pc_reg = 32'hFFFF_FFFF;
      @(negedge clk);
      reset              = 1'b1;
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = mem_model[9];
      @(negedge clk);
      mem_bus.mem_rvalid = 1'b0;
      $display("abort: late response dropped, instr=%h valid=%b", instr, instr_valid);
      total_cnt++; if (instr_valid !== 1'b0) $display("FAIL abort_valid got=%b exp=0", instr_valid); else pass_cnt++;
      total_cnt++; if (instr !== 32'h0) $display("FAIL abort_instr got=%h exp=0", instr); else pass_cnt++;
      total_cnt++; if (pc_hold !== 1'b0 || mem_bus.mem_req !== 1'b0) $display("FAIL abort_idle hold=%b req=%b exp=0/0", pc_hold, mem_bus.mem_req); else pass_cnt++;
      // PC wrapping from the invalid value to 0 is a new fetch of word 0.
      run_fetch(32'd0, mem_model[0], 0, 1, 1'b0, vc, vcyc, rc, iv, hb, ab, ht, hv, ep);
      $display("wrap: pc=0 instr=%h", iv);
      total_cnt++; if (iv !== mem_model[0] || vc != 1) $display("FAIL wrap_instr got=%h cnt=%0d exp=%h cnt=1", iv, vc, mem_model[0]); else pass_cnt++;
   endtask

   task automatic test_halt_instr();
      int vc, vcyc, rc, hb, ab, reqs, lows, pulses; logic [31:0] iv; logic ht, hv, ep;
      mem_model[2] = ECALL;
      run_fetch(32'd2, ECALL, 0, 1, 1'b0, vc, vcyc, rc, iv, hb, ab, ht, hv, ep);
      $display("ecall: instr=%h finish=%b fault=%b", iv, finish_flag, fault);
      total_cnt++; if (iv !== ECALL || vc != 1) $display("FAIL ecall_instr got=%h cnt=%0d exp=%h cnt=1", iv, vc, ECALL); else pass_cnt++;
      total_cnt++; if (finish_flag !== 1'b1 || fault !== 1'b0) $display("FAIL ecall_flags finish=%b fault=%b exp=1/0", finish_flag, fault); else pass_cnt++;
      total_cnt++; if (hv !== 1'b1) $display("FAIL ecall_hold_at_valid got=%b exp=1", hv); else pass_cnt++;
      reqs = 0; lows = 0; pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_bus.mem_req === 1'b1) reqs++;
         if (pc_hold !== 1'b1) lows++;
         if (instr_valid === 1'b1) pulses++;
         pc_reg = 32'(3 + i);
      end
      $display("halted: req_cycles=%0d hold_low=%0d pulses=%0d", reqs, lows, pulses);
      total_cnt++; if (reqs != 0 || lows != 0 || pulses != 0) $display("FAIL halt_ignores_pc req=%0d hold_low=%0d pulses=%0d exp=0/0/0", reqs, lows, pulses); else pass_cnt++;
      total_cnt++; if (finish_flag !== 1'b1) $display("FAIL halt_sticky got=%b exp=1", finish_flag); else pass_cnt++;
      do_reset(2);
      mem_model[5] = EBREAK;
      run_fetch(32'd5, EBREAK, 1, 1, 1'b0, vc, vcyc, rc, iv, hb, ab, ht, hv, ep);
      $display("ebreak: instr=%h finish=%b fault=%b", iv, finish_flag, fault);
      total_cnt++; if (iv !== EBREAK || finish_flag !== 1'b1 || fault !== 1'b0) $display("FAIL ebreak instr=%h finish=%b fault=%b exp=%h/1/0", iv, finish_flag, fault, EBREAK); else pass_cnt++;
   endtask

   task automatic test_out_of_range();
      int vc, vcyc, rc, hb, ab, reqs; logic [31:0] iv; logic ht, hv, ep;
      do_reset(2);
      run_fetch(32'(DEPTH - 1), mem_model[DEPTH - 1], 0, 1, 1'b0, vc, vcyc, rc, iv, hb, ab, ht, hv, ep);
      $display("last_word: pc=%0d instr=%h", DEPTH - 1, iv);
      total_cnt++; if (iv !== mem_model[DEPTH - 1] || vc != 1 || finish_flag !== 1'b0) $display("FAIL last_word got=%h cnt=%0d finish=%b exp=%h/1/0", iv, vc, finish_flag, mem_model[DEPTH - 1]); else pass_cnt++;
      @(negedge clk);
      pc_reg = 32'(DEPTH);
      #1;
      total_cnt++; if (pc_hold !== 1'b1) $display("FAIL oor_hold got=%b exp=1", pc_hold); else pass_cnt++;
      @(negedge clk);
      $display("out_of_range: pc=%0d finish=%b fault=%b", DEPTH, finish_flag, fault);
      total_cnt++; if (finish_flag !== 1'b1 || fault !== 1'b1) $display("FAIL oor_flags finish=%b fault=%b exp=1/1", finish_flag, fault); else pass_cnt++;
      reqs = 0;
      for (int i = 0; i < 4; i++) begin
         if (mem_bus.mem_req === 1'b1) reqs++;
         @(negedge clk);
      end
      total_cnt++; if (reqs != 0) $display("FAIL oor_no_req got=%0d exp=0", reqs); else pass_cnt++;
   endtask

`ifdef IFETCH_TIMEOUT_EN
   task automatic test_timeout();
      int first_fault, pulses; bit granted;
      do_reset(2);
      @(negedge clk); pc_reg = 32'd7;
      first_fault = -1; pulses = 0; granted = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         mem_bus.mem_gnt = 1'b0;
         if (instr_valid === 1'b1) pulses++;
         if (fault === 1'b1 && first_fault < 0) first_fault = cyc;
         if (mem_bus.mem_req === 1'b1 && !granted) begin
            mem_bus.mem_gnt = 1'b1;
            granted = 1;
         end
      end
      mem_bus.mem_gnt = 1'b0;
      $display("timeout: fault first seen at cycle %0d", first_fault);
      total_cnt++; if (first_fault != TIMEOUT_CYCLES + 1) $display("FAIL timeout_cycle got=%0d exp=%0d", first_fault, TIMEOUT_CYCLES + 1); else pass_cnt++;
      total_cnt++; if (finish_flag !== 1'b1 || pulses != 0) $display("FAIL timeout_flags finish=%b pulses=%0d exp=1/0", finish_flag, pulses); else pass_cnt++;
   endtask
`endif

   initial begin
      reset              = 1'b0;
      pc_reg             = 32'hFFFF_FFFF;
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = '0;
      last_pc            = 32'hFFFF_FFFF;
      for (int i = 0; i < DEPTH; i++) begin
         mem_model[i] = $urandom;
         if (mem_model[i] == ECALL || mem_model[i] == EBREAK) mem_model[i] = mem_model[i] ^ 32'h1;
      end
      test_reset();
      test_basic_fetch();
      test_delayed_mem();
      test_random_fetch();
      test_reset_in_wait();
      test_halt_instr();
      test_out_of_range();
`ifdef IFETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not complete");
      $fatal(1, "simulation time limit");
   end

endmodule
